rr_merge_2to1: RTL and testbench
================================

// Module: rr_merge_2to1
// PURPOSE
//   Two-input round-robin stream merger with a one-entry registered output.
//   Arbitrates two valid/ready producers, drives the select of a WIDTH-wide
//   2:1 mux, and captures the chosen word in an output register.
//   Sits directly upstream of the mux path and feeds one downstream consumer.
// PARAMETERS
//   WIDTH  8  data width of each input and the output, in bits (>=1)
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst        in   1      asynchronous, active-high reset
//   in0_valid  in   1      producer 0 presents a word
//   in0_data   in   WIDTH  producer 0 word
//   in0_ready  out  1      word on in0 is accepted this cycle
//   in1_valid  in   1      producer 1 presents a word
//   in1_data   in   WIDTH  producer 1 word
//   in1_ready  out  1      word on in1 is accepted this cycle
//   out_valid  out  1      output register holds a word
//   out_data   out  WIDTH  registered word
//   out_src    out  1      source of out_data: 0 = in0, 1 = in1
//   out_ready  in   1      consumer takes the word this cycle
// BEHAVIOUR
//   Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, last=1.
//     in0_ready and in1_ready are 0 while rst=1.
//   State: out_valid (FULL/EMPTY), out_data, out_src, last (last grantee).
//   load = ~out_valid | out_ready   (register empty, or drained this cycle).
//   Grant, combinational:
//     only in0_valid             -> grant 0
//     only in1_valid             -> grant 1
//     both valid                 -> grant ~last (alternate)
//     neither                    -> no grant
//   sel = granted index; it drives the 2:1 mux, in0_data/in1_data -> mux_out.
//   inX_ready = load & (grant == X) & inX_valid. At most one ready is high.
//   Transfer on inX occurs when inX_valid & inX_ready are both 1 at a clock edge.
//   On that edge: out_data<=mux_out, out_src<=X, out_valid<=1, last<=X.
//   On a load edge with no grant: out_valid<=0 if out_ready, else unchanged.
//   Output transfer occurs when out_valid & out_ready are both 1.
//   Transfer with out_valid=1, out_ready=1 and a new grant is a simultaneous
//     drain+fill. out_valid stays 1 and the new word replaces the old one.
//     Full throughput is 1 word per cycle.
//   FULL with out_ready=0: both readies are 0. out_data and out_src hold stable.
//   Latency: an accepted input appears on out_* one cycle after acceptance.
//   Producers must hold valid/data stable until accepted. No word is
//     dropped or duplicated.
//   last updates only on an input transfer. An idle cycle does not change
//     priority.
//   Reset mid-operation discards a buffered word. After reset, in0 wins the
//     first contention.
//   No combinational path runs from out_ready to out_valid/out_data.
//   The only paths are out_ready -> inX_ready.
// TESTING
//   1 reset: rst=1 async mid-cycle with out_valid=1 -> out_valid=0,
//     out_data=0, out_src=0 immediately; both readies 0.
//   2 single source: in0_valid=1, data 0xA5, out_ready=1 -> in0_ready=1;
//     next cycle out_valid=1, out_data=0xA5, out_src=0.
//   3 contention: both valid every cycle (in0=0x11, in1=0x22), out_ready=1,
//     after reset -> outputs 0x11,0x22,0x11,0x22 with out_src 0,1,0,1.
//   4 backpressure: out_valid=1, out_ready=0 for 3 cycles with both inputs
//     valid -> readies 0, out_data unchanged. Release -> next word is taken
//     the same cycle.
//   5 throughput: in1 streams 0x01..0x08, out_ready=1 -> 8 words on 8
//     consecutive cycles, in order, out_src=1.
//   6 idle keeps priority: grant in1 (0x22), 2 idle cycles, then both valid
//     -> in0 wins (0x11).

Source files
------------

// File: rtl/rr_merge_2to1_if.sv
// Stream bundle for the 2:1 round-robin merger: two producer ports and one
// consumer port. The merger connects through the slave modport and whatever
// drives it connects through the master modport.
interface rr_merge_2to1_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    // Producer/consumer side
    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );

    // Merger side
    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_merge_2to1.sv
// Two-input round-robin stream merger with a one-entry registered output.
// When both producers are valid the grant alternates away from the last
// grantee; idle cycles leave the priority untouched. The output register
// can drain and refill on the same edge, so throughput is one word/cycle.
module rr_merge_2to1 #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    rr_merge_2to1_if.slave bus
);
    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic             src_q;
    logic             last_q;

    logic             load;
    logic             grant_vld;
    logic             sel;
    logic [WIDTH-1:0] mux_out;

    // Grant decision and mux select; out_ready only reaches the readies.
    always_comb begin
        load      = (state_q == StEmpty) | bus.out_ready;
        grant_vld = bus.in0_valid | bus.in1_valid;
        if (bus.in0_valid && bus.in1_valid) begin
            sel = ~last_q;
        end else begin
            sel = bus.in1_valid;
        end
        mux_out       = sel ? bus.in1_data : bus.in0_data;
        // Readies are forced low while reset is held.
        bus.in0_ready = ~rst & load & grant_vld & ~sel & bus.in0_valid;
        bus.in1_ready = ~rst & load & grant_vld &  sel & bus.in1_valid;
    end

    // Output register state: fill on a grant, drain when the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else if (load && grant_vld) begin
            state_q <= StFull;
            data_q  <= mux_out;
            src_q   <= sel;
            last_q  <= sel;
        end else if (bus.out_ready) begin
            state_q <= StEmpty;
        end
    end

    // Registered outputs straight from state.
    always_comb begin
        bus.out_valid = (state_q == StFull);
        bus.out_data  = data_q;
        bus.out_src   = src_q;
    end
endmodule

// File: tb/tb_rr_merge_2to1.sv
// Directed bench for rr_merge_2to1: reset, single source, contention,
// backpressure, streaming throughput and priority retention across idle.
module tb_rr_merge_2to1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    rr_merge_2to1_if #(.WIDTH(8)) bus ();

    rr_merge_2to1 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in0_valid = 1'b0;
        bus.in0_data  = '0;
        bus.in1_valid = 1'b0;
        bus.in1_data  = '0;
        bus.out_ready = 1'b0;

        // Held in reset: everything idle, ready gated even with a valid.
        tick();
        bus.in0_valid = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in0_ready", 32'(bus.in0_ready), 0);

        // Single source
        rst = 1'b0;
        bus.in0_data  = 8'hA5;
        bus.out_ready = 1'b1;
        #1;
        check("single_in0_ready", 32'(bus.in0_ready), 1);
        check("single_in1_ready", 32'(bus.in1_ready), 0);
        tick();
        bus.in0_valid = 1'b0;
        check("single_out_valid", 32'(bus.out_valid), 1);
        check("single_out_data", 32'(bus.out_data), 32'hA5);
        check("single_out_src", 32'(bus.out_src), 0);

        // Async reset mid-cycle with a buffered word
        bus.out_ready = 1'b0;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_out_data", 32'(bus.out_data), 0);
        check("arst_out_src", 32'(bus.out_src), 0);
        check("arst_in0_ready", 32'(bus.in0_ready), 0);
        check("arst_in1_ready", 32'(bus.in1_ready), 0);

        // Contention after reset: in0 first, then alternate
        tick();
        rst = 1'b0;
        bus.in0_data  = 8'h11;
        bus.in1_data  = 8'h22;
        bus.out_ready = 1'b1;
        #1;
        check("cont_first_in0_ready", 32'(bus.in0_ready), 1);
        check("cont_first_in1_ready", 32'(bus.in1_ready), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cont_out_valid", 32'(bus.out_valid), 1);
            check("cont_out_data", 32'(bus.out_data), (i % 2 == 0) ? 32'h11 : 32'h22);
            check("cont_out_src", 32'(bus.out_src), (i % 2 == 0) ? 0 : 1);
        end

        // Backpressure: full with 0x22 from in1, both inputs still valid
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in0_ready", 32'(bus.in0_ready), 0);
            check("bp_in1_ready", 32'(bus.in1_ready), 0);
            check("bp_out_data", 32'(bus.out_data), 32'h22);
            check("bp_out_src", 32'(bus.out_src), 1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in0_ready", 32'(bus.in0_ready), 1);
        tick();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        check("bp_release_out_data", 32'(bus.out_data), 32'h11);
        check("bp_release_out_src", 32'(bus.out_src), 0);

        // Throughput: in1 streams 1..8 back to back
        bus.in1_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in1_data = 8'(i);
            #1;
            check("tp_in1_ready", 32'(bus.in1_ready), 1);
            tick();
            check("tp_out_valid", 32'(bus.out_valid), 1);
            check("tp_out_data", 32'(bus.out_data), 32'(i));
            check("tp_out_src", 32'(bus.out_src), 1);
        end
        bus.in1_valid = 1'b0;

        // Idle keeps priority: in1 granted, two idle cycles, then in0 wins
        bus.in1_valid = 1'b1;
        bus.in1_data  = 8'h22;
        tick();
        bus.in1_valid = 1'b0;
        check("idle_grant_data", 32'(bus.out_data), 32'h22);
        tick();
        check("idle_drained", 32'(bus.out_valid), 0);
        tick();
        check("idle_still_empty", 32'(bus.out_valid), 0);
        bus.in0_valid = 1'b1;
        bus.in0_data  = 8'h11;
        bus.in1_valid = 1'b1;
        #1;
        check("idle_in0_ready", 32'(bus.in0_ready), 1);
        check("idle_in1_ready", 32'(bus.in1_ready), 0);
        tick();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        check("idle_out_data", 32'(bus.out_data), 32'h11);
        check("idle_out_src", 32'(bus.out_src), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
